// File: rtl/data_sram_resp.sv
// data_sram_resp: responder end of the core's sram-like data interface.
// Requests are accepted on data_sram_req/addr_ok. Stores commit to the
// internal byte-writable RAM at the accept edge. Loads capture the whole
// addressed word at the accept edge. Responses come back in order on
// data_ok/rdata, LATENCY cycles after accept, and at most MAX_OUTSTANDING
// requests can be in flight.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   data_sram_req        request valid
//   data_sram_wr         1 = store, 0 = load
//   data_sram_size       access size (carried for the requester, not used)
//   data_sram_wstrb      byte enables for stores
//   data_sram_addr       byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata      store data
//   data_sram_addr_ok    request accepted this cycle
//   data_sram_data_ok    one response delivered this cycle
//   data_sram_rdata      load data (0 for stores or when the queue is empty)

// One response-queue entry: {is_wr, data, timer} plus its valid bit.
module data_sram_resp_slot #(
  parameter int TIM_W = 1,
  parameter logic [TIM_W-1:0] TIM_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             push_wr,
  input  logic [31:0]      push_data,
  output logic             vld,
  output logic             is_wr,
  output logic [31:0]      data,
  output logic [TIM_W-1:0] timer
);
  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= 1'b0;
      is_wr <= 1'b0;
      data  <= '0;
      timer <= '0;
    end else if (push) begin
      vld   <= 1'b1;
      is_wr <= push_wr;
      data  <= push_data;
      timer <= TIM_INIT;
    end else begin
      if (pop) vld <= 1'b0;
      // Non-head entries keep counting down while they wait, so a late
      // entry retires the cycle right after its predecessor.
      if (vld && timer != '0) timer <= timer - 1'b1;
    end
  end
endmodule

module data_sram_resp #(
  parameter int ADDR_W          = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TIM_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TIM_W-1:0] TIM_INIT = TIM_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [MAX_OUTSTANDING-1:0]            slot_vld, slot_wr;
  logic [MAX_OUTSTANDING-1:0][31:0]      slot_data;
  logic [MAX_OUTSTANDING-1:0][TIM_W-1:0] slot_timer;

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              push, pop, has_entry;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Size and the address bits outside the word index are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                         data_sram_addr[1:0], slot_vld};

  assign word_idx  = data_sram_addr[ADDR_W+1:2];
  assign has_entry = (count != '0);

  // Occupancy is registered, so a retirement this cycle frees its slot only
  // next cycle; addr_ok never depends on data_ok.
  assign data_sram_addr_ok = data_sram_req && !reset && (count < CNT_MAX);
  assign push = data_sram_addr_ok;

  assign data_sram_data_ok = has_entry && !reset && (slot_timer[head] == '0);
  assign pop = data_sram_data_ok;

  assign data_sram_rdata = (has_entry && !reset && !slot_wr[head]) ? slot_data[head] : '0;

  // Stores commit at the accept edge. A load accepted on a later edge
  // therefore sees the new value, including back-to-back accepts.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // The load word is read in the accept cycle and frozen into the queue entry.
  assign rd_word = mem[word_idx];

  for (genvar i = 0; i < MAX_OUTSTANDING; i++) begin : g_slot
    data_sram_resp_slot #(.TIM_W(TIM_W), .TIM_INIT(TIM_INIT)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .push      (push && (tail == PTR_W'(i))),
      .pop       (pop && (head == PTR_W'(i))),
      .push_wr   (data_sram_wr),
      .push_data (data_sram_wr ? 32'd0 : rd_word),
      .vld       (slot_vld[i]),
      .is_wr     (slot_wr[i]),
      .data      (slot_data[i]),
      .timer     (slot_timer[i])
    );
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
  localparam int LAT  = 2;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance: LATENCY=2, MAX_OUTSTANDING=2.
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;

  // Throughput instance: LATENCY=1, MAX_OUTSTANDING=2.
  logic        f_req, f_wr;
  logic [1:0]  f_size;
  logic [3:0]  f_wstrb;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic        f_addr_ok, f_data_ok;

  data_sram_resp #(.ADDR_W(12), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata)
  );

  data_sram_resp #(.ADDR_W(12), .LATENCY(1), .MAX_OUTSTANDING(2)) dut_fast (
    .clk(clk), .reset(reset),
    .data_sram_req(f_req), .data_sram_wr(f_wr), .data_sram_size(f_size),
    .data_sram_wstrb(f_wstrb), .data_sram_addr(f_addr), .data_sram_wdata(f_wdata),
    .data_sram_addr_ok(f_addr_ok), .data_sram_data_ok(f_data_ok), .data_sram_rdata(f_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t sb[$];        // expected responses, in order
  int   dues[$];      // retire cycles of everything the model thinks is in flight
  int   last_due = -100;
  logic [31:0] model [16];
  logic [31:0] fexp [8];
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s expired wait (cycle %0d)", name, cyc);
  endtask

  // Monitor: pop and compare every delivered response.
  always @(negedge clk) begin
    if (data_ok) begin
      if (sb.size() == 0) fail("spurious_data_ok");
      else begin
        me = sb.pop_front();
        chk("rdata", rdata, me.data);
        chk("data_ok_cycle", cyc, me.due);
      end
    end else if (sb.size() == 0) begin
      chk("idle_rdata", rdata, 32'd0);
    end
  end

  // Issue one request; holds req until accepted. The model predicts addr_ok
  // from how many responses are still owed, and the expected response and
  // its delivery cycle are queued at accept.
  task automatic issue(input logic w, input logic [3:0] st, input logic [31:0] a,
                       input logic [31:0] d, output int waits);
    exp_t e;
    int   idx;
    bit   ok;
    bit   exp_ok;
    wr = w; wstrb = st; addr = a; wdata = d; size = 2'd2; req = 1'b1;
    waits = 0; ok = 0;
    while (!ok) begin
      @(negedge clk);
      while (dues.size() != 0 && dues[0] < cyc) void'(dues.pop_front());
      exp_ok = (dues.size() < MAXO);
      chk("addr_ok", {31'd0, addr_ok}, {31'd0, exp_ok});
      if (addr_ok) ok = 1;
      else begin
        waits++;
        if (waits > 60) begin fail("accept_timeout"); break; end
        @(posedge clk); #1;
      end
    end
    if (ok) begin
      idx = int'(a[5:2]);
      if (w) begin
        for (int b = 0; b < 4; b++) if (st[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        e.data = 32'd0;
      end else e.data = model[idx];
      e.due = cyc + LAT;
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      sb.push_back(e);
      dues.push_back(e.due);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  // 10 cycles on the LATENCY=1 instance: 8 back-to-back requests, then idle.
  task automatic fast_burst(input logic w);
    for (int i = 0; i < 10; i++) begin
      f_req = (i < 8); f_wr = w; f_wstrb = 4'hF; f_addr = 32'(i * 4); f_size = 2'd2;
      if (w && i < 8) begin f_wdata = $urandom; fexp[i] = f_wdata; end
      @(negedge clk);
      if (i < 8) chk("fast_addr_ok", {31'd0, f_addr_ok}, 32'd1);
      chk("fast_data_ok", {31'd0, f_data_ok}, (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 8) chk("fast_rdata", f_rdata, w ? 32'd0 : fexp[i-1]);
      @(posedge clk); #1;
    end
    f_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w0, w1, w2, wt;
    logic [31:0] r;
    reset = 1'b1;
    req = 0; wr = 0; size = 0; wstrb = 0; addr = 0; wdata = 0;
    f_req = 0; f_wr = 0; f_size = 0; f_wstrb = 0; f_addr = 0; f_wdata = 0;
    repeat (2) @(posedge clk);
    #1 req = 1'b1;
    @(negedge clk);
    chk("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("reset_data_ok", {31'd0, data_ok}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_reset_count", 32'(dut.count), 32'd0);
    chk("post_reset_data_ok", {31'd0, data_ok}, 32'd0);
    @(posedge clk); #1;

    // Give every word the model tracks a known value.
    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom, wt);
    drain();

    // Single store then load.
    issue(1'b1, 4'hF, 32'h10, 32'hA1B2C3D4, wt);
    issue(1'b0, 4'h0, 32'h10, 32'h0, wt);
    drain();
    chk("model_t1", model[4], 32'hA1B2C3D4);

    // Byte strobe store, then load.
    issue(1'b1, 4'b0100, 32'h12, 32'h00EE0000, wt);
    issue(1'b0, 4'h0, 32'h10, 32'h0, wt);
    drain();
    chk("model_t2", model[4], 32'hA1EEC3D4);

    // Back-to-back hazard: third request stalls exactly one cycle.
    issue(1'b1, 4'hF, 32'h20, 32'h11111111, w0);
    issue(1'b0, 4'h0, 32'h20, 32'h0, w1);
    issue(1'b0, 4'h0, 32'h24, 32'h0, w2);
    chk("hazard_wait0", 32'(w0), 32'd0);
    chk("hazard_wait1", 32'(w1), 32'd0);
    chk("hazard_wait2", 32'(w2), 32'd1);
    drain();

    // wstrb = 0 store still responds and leaves memory alone.
    issue(1'b1, 4'h0, 32'h10, 32'hDEADBEEF, wt);
    issue(1'b0, 4'h0, 32'h10, 32'h0, wt);
    drain();

    // Randomized traffic: misaligned offsets, junk upper bits, random gaps.
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      r = $urandom;
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            {r[31:14], 8'd0, 6'($urandom_range(0, 63))}, $urandom, wt);
    end
    drain();

    // Reset with two loads in flight.
    issue(1'b0, 4'h0, 32'h04, 32'h0, wt);
    issue(1'b0, 4'h0, 32'h08, 32'h0, wt);
    reset = 1'b1;
    sb.delete(); dues.delete(); last_due = -100;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("flush_data_ok", {31'd0, data_ok}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(1'b0, 4'h0, 32'h10, 32'h0, wt);
    drain();

    // Full throughput on the LATENCY=1 instance.
    fast_burst(1'b1);
    fast_burst(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
